fpnew_divsqrt_iter_core: RTL and testbench

//  Iterative radix-2 mantissa divide / square-root core that responds to the start/kill/ready/done

---
 rtl/fpnew_divsqrt_iter_core.sv | 138 +++++++++++++
 tb/tb_fpnew_divsqrt_iter_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_divsqrt_iter_core.sv
// Radix-2 iterative mantissa divide / square-root core, one result bit per cycle.
// Responds to the wrapper's start/kill/ready/done handshake; rounding stays outside.
module fpnew_divsqrt_iter_core #(
  parameter int unsigned  MANT_WIDTH = 53,
  localparam int unsigned Q_WIDTH    = MANT_WIDTH + 2,
  localparam int unsigned CNT_WIDTH  = $clog2(Q_WIDTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  div_start_i,
  input  logic                  sqrt_start_i,
  input  logic                  kill_i,
  input  logic [MANT_WIDTH-1:0] mant_a_i,
  input  logic [MANT_WIDTH-1:0] mant_b_i,
  input  logic                  exp_odd_i,
  input  logic [CNT_WIDTH-1:0]  iters_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [Q_WIDTH-1:0]    quotient_o,
  output logic                  sticky_o,
  output logic                  busy_o
);

  // Sqrt remainder can reach ~4*root before the compare, hence two bits above Q_WIDTH.
  localparam int unsigned REM_W = Q_WIDTH + 2;
  localparam int unsigned RAD_W = 2 * Q_WIDTH;
  localparam logic [CNT_WIDTH-1:0] Q_CNT = CNT_WIDTH'(Q_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q;
  logic                  ready_q, done_q, busy_q, op_sqrt_q;
  logic [CNT_WIDTH-1:0]  iters_q, cnt_q, iters_clamped;
  logic [MANT_WIDTH-1:0] divisor_q;
  logic [REM_W-1:0]      rem_q, rem_d, rem_sh, trial, divisor_ext;
  logic [RAD_W-1:0]      rad_q, rad_d, rad_init;
  logic [Q_WIDTH-1:0]    acc_q, acc_d;
  logic                  accept, last_iter, q_bit;

  assign accept    = (div_start_i | sqrt_start_i) & ready_q & ~kill_i;
  assign last_iter = (cnt_q == iters_q - 1'b1);
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q & ~kill_i;

  always_comb begin
    iters_clamped = iters_i;
    if (iters_i == '0) begin
      iters_clamped = CNT_WIDTH'(1);
    end else if (iters_i > Q_CNT) begin
      iters_clamped = Q_CNT;
    end
  end

  // Radicand scaled so that its integer square root is the Q_WIDTH-bit result.
  assign rad_init = {exp_odd_i ? {mant_a_i, 1'b0} : {1'b0, mant_a_i},
                     {(MANT_WIDTH + 3){1'b0}}};

  always_comb begin
    divisor_ext = {{(REM_W - MANT_WIDTH){1'b0}}, divisor_q};
    rem_sh      = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    trial       = {acc_q, 2'b01};
    rad_d       = rad_q << 2;
    if (op_sqrt_q) begin
      q_bit = (rem_sh >= trial);
      rem_d = q_bit ? rem_sh - trial : rem_sh;
    end else begin
      q_bit = (rem_q >= divisor_ext);
      rem_d = (q_bit ? rem_q - divisor_ext : rem_q) << 1;
    end
    acc_d = {acc_q[Q_WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      op_sqrt_q  <= 1'b0;
      iters_q    <= '0;
      cnt_q      <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      rad_q      <= '0;
      acc_q      <= '0;
      quotient_o <= '0;
      sticky_o   <= 1'b0;
    end else if (kill_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q   <= BUSY;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            op_sqrt_q <= ~div_start_i;
            iters_q   <= iters_clamped;
            cnt_q     <= '0;
            divisor_q <= mant_b_i;
            acc_q     <= '0;
            rem_q     <= div_start_i ? {{(REM_W - MANT_WIDTH){1'b0}}, mant_a_i} : '0;
            rad_q     <= div_start_i ? '0 : rad_init;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          rad_q <= rad_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q    <= DONE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            quotient_o <= acc_d << (Q_CNT - iters_q);
            sticky_o   <= (rem_d != '0) || (rad_d != '0);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpnew_divsqrt_iter_core.sv
// Bench for fpnew_divsqrt_iter_core: directed handshake cases plus random operands
// checked against an arithmetic reference model.
module tb_fpnew_divsqrt_iter_core;

  localparam int MW = 8;
  localparam int QW = MW + 2;
  localparam int CW = $clog2(QW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          div_start = 1'b0;
  logic          sqrt_start = 1'b0;
  logic          kill = 1'b0;
  logic          exp_odd = 1'b0;
  logic [MW-1:0] mant_a = '0;
  logic [MW-1:0] mant_b = '0;
  logic [CW-1:0] iters = '0;
  logic          ready, done, sticky, busy;
  logic [QW-1:0] quotient;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [QW-1:0] last_q = '0;
  logic          last_s = 1'b0;

  fpnew_divsqrt_iter_core #(.MANT_WIDTH(MW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .div_start_i  (div_start),
    .sqrt_start_i (sqrt_start),
    .kill_i       (kill),
    .mant_a_i     (mant_a),
    .mant_b_i     (mant_b),
    .exp_odd_i    (exp_odd),
    .iters_i      (iters),
    .ready_o      (ready),
    .done_o       (done),
    .quotient_o   (quotient),
    .sticky_o     (sticky),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Callers must only present normalized operands on an accepted start.
  always @(posedge clk) begin
    if (rst_n && ready && (div_start || sqrt_start)) begin
      assert (mant_a[MW-1] && (!div_start || mant_b[MW-1]))
        else $error("operand precondition violated: a=%0h b=%0h", mant_a, mant_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clamp_iters(input int it);
    if (it == 0) return 1;
    if (it > QW) return QW;
    return it;
  endfunction

  // Result = top 'it' bits of the exact quotient/root, left-aligned in QW bits.
  function automatic void model(input bit sq, input logic [MW-1:0] a, input logic [MW-1:0] b,
                                input bit odd, input int it_in,
                                output logic [QW-1:0] q, output logic s);
    int     it, k;
    longint num, qi, m, lo, hi, mid;
    it = clamp_iters(it_in);
    k  = QW - it;
    if (!sq) begin
      num = longint'(a) << (it - 1);
      qi  = num / longint'(b);
      s   = (num % longint'(b)) != 0;
    end else begin
      m  = (longint'(a) * (odd ? 2 : 1)) << (MW + 3);
      lo = 0;
      hi = 4096;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (mid * mid <= m) lo = mid;
        else hi = mid;
      end
      qi = lo >> k;
      s  = ((qi << k) * (qi << k)) != m;
    end
    q = QW'(qi << k);
  endfunction

  task automatic wait_ready();
    for (int n = 0; n < 50 && !ready; n++) @(negedge clk);
    if (!ready) check("ready_timeout", ready, 1'b1);
  endtask

  task automatic drive_start(input bit sq, input bit dual, input logic [MW-1:0] a,
                             input logic [MW-1:0] b, input bit odd, input logic [CW-1:0] it);
    div_start  = dual | ~sq;
    sqrt_start = sq | dual;
    mant_a     = a;
    mant_b     = b;
    exp_odd    = odd;
    iters      = it;
  endtask

  task automatic scramble();
    div_start  = 1'b0;
    sqrt_start = 1'b0;
    mant_a     = MW'($urandom);
    mant_b     = MW'($urandom);
    exp_odd    = 1'($urandom);
    iters      = CW'($urandom);
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int c, input int d, input int eff,
                              input logic [QW-1:0] eq, input logic es);
    if (d < 0) begin
      check({tag, "_done_timeout"}, done, 1'b1);
    end else begin
      check({tag, "_latency"}, d - c, eff + 1);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_sticky"}, sticky, es);
    end
    last_q = eq;
    last_s = es;
  endtask

  task automatic run_op(input string tag, input bit sq, input bit dual, input logic [MW-1:0] a,
                        input logic [MW-1:0] b, input bit odd, input logic [CW-1:0] it);
    logic [QW-1:0] eq;
    logic          es;
    int            c, d;
    model(sq & ~dual, a, b, odd, int'(it), eq, es);
    wait_ready();
    drive_start(sq, dual, a, b, odd, it);
    c = cyc;
    @(negedge clk);
    scramble();
    wait_done(d);
    check_result(tag, c, d, clamp_iters(int'(it)), eq, es);
    if (d >= 0) begin
      @(negedge clk);
      check({tag, "_pulse"}, done, 1'b0);
      check({tag, "_hold"}, quotient, eq);
      check({tag, "_ready"}, ready, 1'b1);
    end
  endtask

  initial begin
    logic [QW-1:0] e1q, e2q;
    logic          e1s, e2s;
    int            c, d, c2, d2, seen;

    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_sticky", sticky, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_c0_80", 1'b0, 1'b0, 8'hC0, 8'h80, 1'b0, 4'd10);
    run_op("div_80_c0", 1'b0, 1'b0, 8'h80, 8'hC0, 1'b0, 4'd10);
    run_op("div_80_c0_i5", 1'b0, 1'b0, 8'h80, 8'hC0, 1'b0, 4'd5);
    run_op("sqrt_even", 1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 4'd10);
    run_op("sqrt_odd", 1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 4'd10);
    run_op("iters_zero", 1'b0, 1'b0, 8'hC0, 8'h80, 1'b0, 4'd0);
    run_op("iters_one", 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 4'd1);
    run_op("iters_clamp", 1'b0, 1'b0, 8'hFF, 8'h81, 1'b0, 4'd15);
    run_op("dual_start", 1'b1, 1'b1, 8'hC0, 8'h80, 1'b1, 4'd10);

    // Start pulse while busy must be ignored.
    model(1'b0, 8'h80, 8'hC0, 1'b0, 10, e1q, e1s);
    wait_ready();
    drive_start(1'b0, 1'b0, 8'h80, 8'hC0, 1'b0, 4'd10);
    c = cyc;
    @(negedge clk);
    scramble();
    repeat (2) @(negedge clk);
    drive_start(1'b1, 1'b1, 8'hFF, 8'h80, 1'b1, 4'd3);
    @(negedge clk);
    scramble();
    wait_done(d);
    check_result("busy_start", c, d, 10, e1q, e1s);

    // Back-to-back: second start in the done cycle.
    model(1'b0, 8'hA7, 8'hE3, 1'b0, 10, e1q, e1s);
    model(1'b1, 8'h9B, 8'h00, 1'b1, 10, e2q, e2s);
    wait_ready();
    drive_start(1'b0, 1'b0, 8'hA7, 8'hE3, 1'b0, 4'd10);
    c = cyc;
    @(negedge clk);
    scramble();
    wait_done(d);
    check_result("b2b_first", c, d, 10, e1q, e1s);
    drive_start(1'b1, 1'b0, 8'h9B, 8'h00, 1'b1, 4'd10);
    c2 = cyc;
    @(negedge clk);
    scramble();
    check("b2b_busy", busy, 1'b1);
    repeat (8) @(negedge clk);
    check("b2b_hold_q", quotient, e1q);
    check("b2b_hold_s", sticky, e1s);
    wait_done(d2);
    check_result("b2b_second", c2, d2, 10, e2q, e2s);
    @(negedge clk);

    // Kill at the fourth iteration.
    wait_ready();
    drive_start(1'b0, 1'b0, 8'h80, 8'hC0, 1'b0, 4'd10);
    @(negedge clk);
    scramble();
    repeat (3) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_ready", ready, 1'b1);
    check("kill_busy", busy, 1'b0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("kill_no_done", seen, 0);
    check("kill_hold_q", quotient, last_q);

    // Kill together with start: nothing begins.
    drive_start(1'b0, 1'b0, 8'hC0, 8'h80, 1'b0, 4'd4);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    scramble();
    check("killstart_busy", busy, 1'b0);
    check("killstart_ready", ready, 1'b1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("killstart_no_done", seen, 0);

    // Kill during the done cycle masks the pulse.
    model(1'b1, 8'hD5, 8'h00, 1'b0, 7, e1q, e1s);
    wait_ready();
    drive_start(1'b1, 1'b0, 8'hD5, 8'h00, 1'b0, 4'd7);
    c = cyc;
    @(negedge clk);
    scramble();
    wait_done(d);
    check_result("killdone", c, d, 7, e1q, e1s);
    kill = 1'b1;
    #1;
    check("killdone_masked", done, 1'b0);
    @(negedge clk);
    kill = 1'b0;
    check("killdone_ready", ready, 1'b1);
    check("killdone_hold", quotient, e1q);

    for (int i = 0; i < 40; i++) begin
      bit            sq, du, od;
      logic [MW-1:0] a, b;
      logic [CW-1:0] it;
      sq = 1'($urandom_range(0, 1));
      du = ($urandom_range(0, 7) == 0);
      od = 1'($urandom_range(0, 1));
      a  = {1'b1, 7'($urandom)};
      b  = {1'b1, 7'($urandom)};
      it = CW'($urandom_range(0, 15));
      run_op("random", sq, du, a, b, od, it);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
